tensor_fetch: RTL and testbench
===============================

TENSOR_FETCH -- requirements
Module: tensor_fetch

Interface
REQ-001 Parameters: none; widths come from the global macros ADDR_WIDTH, DATA_WIDTH, BANDWIDTH; word width W = DATA_WIDTH*BANDWIDTH.
REQ-002 clock  in  1  single clock; all state changes on its posedge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  fetch request; sampled only in IDLE.
REQ-005 base_addr  in  ADDR_WIDTH  address of the tensor header word.
REQ-006 mem_read  out  1  memory read strobe (initiator side of the one-cycle-latency read port).
REQ-007 mem_address  out  ADDR_WIDTH  read address.
REQ-008 mem_readdata  in  W  memory data, valid the cycle after mem_read; zero otherwise.
REQ-009 out_valid, out_data[W], out_last  out  stream word, valid flag, final-word flag.
REQ-010 out_ready  in  1  consumer accepts when out_valid & out_ready.
REQ-011 rows[7], cols[7]  out  latched header dimensions.
REQ-012 busy  out  1  high from start acceptance until done.
REQ-013 done  out  1  one-cycle completion pulse; error  out  1  one-cycle pulse, coincident with done, for zero-size tensors.

Function
REQ-014 Header layout: bits[6:0]=cols, bits[13:7]=rows, remaining bits ignored.
REQ-015 Word count N = ceil(rows*cols / BANDWIDTH), computed at 14+ bits without overflow.
REQ-016 States: IDLE, HDR_REQ, HDR_WAIT, STREAM, FINISH.
REQ-017 IDLE->HDR_REQ when start=1; base_addr is latched at the same edge; start in any other state is ignored.
REQ-018 HDR_REQ (one cycle): mem_read=1, mem_address=base.
REQ-019 HDR_WAIT (one cycle): rows, cols and N are latched from mem_readdata; if rows=0 or cols=0, go to FINISH with error flagged, else go to STREAM.
REQ-020 STREAM: data word i is read from base+1+i, for i=0..N-1, with addresses wrapping modulo 2^ADDR_WIDTH.
REQ-021 Read issue condition: words_issued<N and (fifo_count + inflight - pop_this_cycle) < 2; memory reads are never stalled, so credits guarantee capacity.
REQ-022 Returned data is pushed into a 2-entry FIFO at the edge ending the return cycle; out_valid = FIFO non-empty; out_data = FIFO head.
REQ-023 out_last=1 exactly on word N-1; out_data/out_last are held stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous push and pop on a full or empty FIFO are both honoured; count is unchanged or updated by the net change.
REQ-025 STREAM->FINISH on the handshake of the last word; FINISH lasts one cycle with done=1 (error=1 if flagged), then goes to IDLE.
REQ-026 Timing with start sampled at edge k: header read in cycle k+1; first data read in k+3; first out_valid in k+5; with out_ready held high, one word per cycle thereafter.
REQ-027 mem_read=0 and mem_address=0 whenever no read is issued.
REQ-028 busy=1 in HDR_REQ, HDR_WAIT and STREAM; busy=0 in IDLE and FINISH.

Reset
REQ-029 reset_n=0 forces IDLE immediately, in any state, including mid-stream.
REQ-030 On reset, the FIFO, counters and inflight are cleared and all outputs go to 0.
REQ-031 After reset, a returning read datum is discarded and the next start begins a clean fetch.

Structure
REQ-032 Shared package tensor_pkg holds the state enum, the header field positions and widths (DIM_W=7), and the FIFO depth constant (2).
REQ-033 One sub-module, word_fifo2: a W-wide, 2-entry FIFO with push/pop/count.
REQ-034 The width macros remain global defines.

Verification
REQ-035 Header {4'd4,7'd16,7'd12,7'd16,7'd12} at base 0, BANDWIDTH=4, out_ready=1 -> rows=16, cols=12, 48 words from addresses 1..48, out_last on the 48th, done one cycle later.
REQ-036 rows=3, cols=5, BANDWIDTH=4 -> 4 words; out_last on word 3.
REQ-037 out_ready toggling 1,0,0,1 on a random pattern -> no word lost or duplicated, at most 2 reads outstanding, data held while stalled.
REQ-038 Header with cols=0 -> no data reads; done=1 and error=1 in the same cycle, 3 cycles after start.
REQ-039 base_addr=2^ADDR_WIDTH-2 with N=3 -> data addresses wrap to 2^ADDR_WIDTH-1, 0, 1.
REQ-040 reset_n pulsed low mid-stream, then start -> outputs 0 during reset; the second fetch completes correctly with no stale word.

Source files
------------

// File: rtl/tensor_pkg.sv
// rtl/tensor_pkg.sv - shared types, header field layout and sizing helpers for tensor_fetch
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif

package tensor_pkg;

  // Header word: cols in the low field, rows directly above it
  localparam int DIM_W      = 7;
  localparam int COLS_LSB   = 0;
  localparam int ROWS_LSB   = 7;

  // Stream buffer depth; also the number of read credits
  localparam int FIFO_DEPTH = 2;

  // Wide enough for 127*127 plus rounding without overflow
  localparam int CNT_W      = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_REQ,
    S_HDR_WAIT,
    S_STREAM,
    S_FINISH
  } fetch_state_t;

  // Number of stream words needed to carry rows*cols elements
  function automatic logic [CNT_W-1:0] word_count(input logic [DIM_W-1:0] r,
                                                  input logic [DIM_W-1:0] c);
    logic [CNT_W-1:0] prod;
    prod = CNT_W'(r) * CNT_W'(c);
    return (prod + CNT_W'(`BANDWIDTH - 1)) / CNT_W'(`BANDWIDTH);
  endfunction

endpackage

// File: rtl/word_fifo2.sv
// rtl/word_fifo2.sv - two-entry word FIFO buffering returned read data
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif

module word_fifo2
  import tensor_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot [FIFO_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  // A pop frees a slot in the same edge, so a push into a full FIFO is fine then
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'(FIFO_DEPTH)) || do_pop);
  assign head    = slot[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/tensor_fetch.sv
// rtl/tensor_fetch.sv - reads a tensor header then streams its data words with credit-based prefetch
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif

module tensor_fetch
  import tensor_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [`ADDR_WIDTH-1:0]               base_addr,
  output logic                                 mem_read,
  output logic [`ADDR_WIDTH-1:0]               mem_address,
  input  logic [`DATA_WIDTH*`BANDWIDTH-1:0]    mem_readdata,
  output logic                                 out_valid,
  output logic [`DATA_WIDTH*`BANDWIDTH-1:0]    out_data,
  output logic                                 out_last,
  input  logic                                 out_ready,
  output logic [DIM_W-1:0]                     rows,
  output logic [DIM_W-1:0]                     cols,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  localparam int AW = `ADDR_WIDTH;
  localparam int W  = `DATA_WIDTH * `BANDWIDTH;

  fetch_state_t     state;
  fetch_state_t     state_d;
  logic [AW-1:0]    base_q;
  logic [DIM_W-1:0] rows_q;
  logic [DIM_W-1:0] cols_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] popped;
  logic             inflight;
  logic             err_q;
  logic [1:0]       fifo_count;
  logic [2:0]       occupancy;
  logic             pop;
  logic             issue;
  logic             on_last;
  logic [DIM_W-1:0] hdr_rows;
  logic [DIM_W-1:0] hdr_cols;

  assign hdr_cols  = mem_readdata[COLS_LSB +: DIM_W];
  assign hdr_rows  = mem_readdata[ROWS_LSB +: DIM_W];
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign on_last   = (popped == n_q - CNT_W'(1));
  assign out_last  = out_valid && on_last;
  assign rows      = rows_q;
  assign cols      = cols_q;

  // Slots already owed to the FIFO (held + in flight) after this cycle's pop
  assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign issue     = (state == S_STREAM) && (issued < n_q) && (occupancy < 3'(FIFO_DEPTH));

  word_fifo2 #(.W(W)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (mem_readdata),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  // Next-state and read-port/status decode
  always_comb begin
    state_d     = state;
    mem_read    = 1'b0;
    mem_address = '0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_d = S_HDR_REQ;
      end
      S_HDR_REQ: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = base_q;
        state_d     = S_HDR_WAIT;
      end
      S_HDR_WAIT: begin
        busy    = 1'b1;
        state_d = ((hdr_rows == '0) || (hdr_cols == '0)) ? S_FINISH : S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (issue) begin
          mem_read    = 1'b1;
          mem_address = base_q + AW'(1) + AW'(issued);
        end
        if (pop && on_last) state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        error   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched header and stream counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      base_q   <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      n_q      <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      inflight <= issue;
      if ((state == S_IDLE) && start) base_q <= base_addr;
      if (state == S_HDR_WAIT) begin
        rows_q <= hdr_rows;
        cols_q <= hdr_cols;
        n_q    <= word_count(hdr_rows, hdr_cols);
        err_q  <= (hdr_rows == '0) || (hdr_cols == '0);
        issued <= '0;
        popped <= '0;
      end
      if (issue) issued <= issued + CNT_W'(1);
      if (pop)   popped <= popped + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tensor_fetch.sv
// tb/tb_tensor_fetch.sv - randomized self-checking bench for tensor_fetch with a memory and stream model
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif

module tb_tensor_fetch;

  localparam int AW    = `ADDR_WIDTH;
  localparam int W     = `DATA_WIDTH * `BANDWIDTH;
  localparam int BW    = `BANDWIDTH;
  localparam int MEMSZ = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_read;
  logic [AW-1:0] mem_address;
  logic [W-1:0]  mem_readdata;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic [6:0]    rows;
  logic [6:0]    cols;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clock = ~clock;

  tensor_fetch dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .rows         (rows),
    .cols         (cols),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  // one-cycle-latency memory, zero when no read was issued
  logic [W-1:0]  mem [MEMSZ];
  logic          rd_q = 1'b0;
  logic [AW-1:0] addr_q = '0;
  always @(posedge clock) begin
    rd_q   <= mem_read;
    addr_q <= mem_address;
  end
  assign mem_readdata = rd_q ? mem[addr_q] : '0;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] wrap(input int a);
    return AW'(a);
  endfunction

  // reference model state for the fetch in progress
  bit          active = 1'b0;
  bit          hdr_seen;
  bit          exp_err;
  bit          last_err;
  int          exp_n;
  int          exp_base;
  int          out_idx;
  int          rd_idx;
  int          cyc;
  int          done_cyc;
  logic [AW-1:0] rd_addrs[$];

  int ready_mode = 0;
  int ph = 0;
  int pat [4] = '{1, 0, 0, 1};

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = 1'(pat[ph % 4]);
          ph++;
        end
      endcase
    end
  end

  // compare process: every cycle out of reset
  always @(negedge clock) begin
    if (reset_n) begin
      if (active) cyc++;
      if (out_valid) begin
        if (!active) chk("stray_valid", 64'(out_valid), 64'(0));
        else begin
          chk("word_in_range", 64'(out_idx < exp_n), 64'(1));
          chk("out_data", 64'(out_data), 64'(mem[wrap(exp_base + 1 + out_idx)]));
          chk("out_last", 64'(out_last), 64'(out_idx == exp_n - 1));
          if (out_ready) out_idx++;
        end
      end else begin
        chk("last_without_valid", 64'(out_last), 64'(0));
      end
      if (mem_read) begin
        if (!active) chk("stray_read", 64'(mem_read), 64'(0));
        else if (!hdr_seen) begin
          chk("hdr_addr", 64'(mem_address), 64'(wrap(exp_base)));
          hdr_seen = 1'b1;
        end else begin
          chk("read_in_range", 64'(rd_idx < exp_n), 64'(1));
          chk("read_addr", 64'(mem_address), 64'(wrap(exp_base + 1 + rd_idx)));
          rd_addrs.push_back(mem_address);
          rd_idx++;
          chk("outstanding_le2", 64'((rd_idx - out_idx) <= 2), 64'(1));
        end
      end else begin
        chk("addr_idle", 64'(mem_address), 64'(0));
      end
      chk("busy", 64'(busy), 64'(active && !done));
      if (done) begin
        chk("done_expected", 64'(active), 64'(1));
        chk("error", 64'(error), 64'(exp_err));
        chk("words_out", 64'(out_idx), 64'(exp_n));
        chk("words_read", 64'(rd_idx), 64'(exp_n));
        done_cyc = cyc;
        last_err = error;
        active   = 1'b0;
      end else begin
        chk("error_without_done", 64'(error), 64'(0));
      end
    end
  end

  task automatic begin_fetch(input logic [W-1:0] hdr, input int base, input int mode);
    int r;
    int c;
    r = int'(hdr[13:7]);
    c = int'(hdr[6:0]);
    mem[wrap(base)] = hdr;
    ready_mode = mode;
    @(negedge clock);
    #1;
    exp_base = base;
    exp_n    = (r == 0 || c == 0) ? 0 : (r * c + BW - 1) / BW;
    exp_err  = (r == 0 || c == 0);
    out_idx  = 0;
    rd_idx   = 0;
    hdr_seen = 1'b0;
    cyc      = 0;
    done_cyc = -1;
    rd_addrs.delete();
    start     = 1'b1;
    base_addr = wrap(base);
    @(posedge clock);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    active    = 1'b1;
  endtask

  task automatic wait_done(input logic [W-1:0] hdr, output int dcyc);
    int k;
    k = 0;
    while (active && k < 5000) begin
      @(posedge clock);
      k++;
    end
    if (active) begin
      chk("fetch_timeout", 64'(0), 64'(1));
      active = 1'b0;
    end
    dcyc = done_cyc;
    chk("rows_latched", 64'(rows), 64'(hdr[13:7]));
    chk("cols_latched", 64'(cols), 64'(hdr[6:0]));
  endtask

  task automatic fetch(input logic [W-1:0] hdr, input int base, input int mode, output int dcyc);
    begin_fetch(hdr, base, mode);
    wait_done(hdr, dcyc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_read"}, 64'(mem_read), 64'(0));
    chk({tag, "_mem_address"}, 64'(mem_address), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    chk({tag, "_out_last"}, 64'(out_last), 64'(0));
    chk({tag, "_rows"}, 64'(rows), 64'(0));
    chk({tag, "_cols"}, 64'(cols), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_error"}, 64'(error), 64'(0));
  endtask

  initial begin
    logic [W-1:0] hdr;
    int d;
    for (int i = 0; i < MEMSZ; i++) mem[i] = W'({$urandom, $urandom});

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;

    // 16x12 tensor, 48 words from addresses 1..48
    hdr = W'({4'd4, 7'd16, 7'd12, 7'd16, 7'd12});
    fetch(hdr, 0, 0, d);
    chk("r35_words", 64'(rd_addrs.size()), 64'(48));
    if (rd_addrs.size() == 48) begin
      chk("r35_first_addr", 64'(rd_addrs[0]), 64'(1));
      chk("r35_last_addr", 64'(rd_addrs[47]), 64'(48));
    end
    chk("r35_done_cycle", 64'(d), 64'(53));
    chk("r35_rows", 64'(rows), 64'(16));
    chk("r35_cols", 64'(cols), 64'(12));

    // 3x5 -> 4 words
    hdr = W'({7'd3, 7'd5});
    fetch(hdr, 20, 0, d);
    chk("r36_words", 64'(out_idx), 64'(4));
    chk("r36_done_cycle", 64'(d), 64'(9));

    // stalled consumer pattern
    hdr = W'({7'd6, 7'd7});
    fetch(hdr, 40, 2, d);
    chk("r37_words", 64'(out_idx), 64'(11));

    // zero-size tensor
    hdr = W'({7'd5, 7'd0});
    fetch(hdr, 60, 0, d);
    chk("r38_done_cycle", 64'(d), 64'(3));
    chk("r38_error", 64'(last_err), 64'(1));
    chk("r38_no_data_reads", 64'(rd_idx), 64'(0));

    // address wrap
    hdr = W'({7'd1, 7'd9});
    fetch(hdr, MEMSZ - 2, 0, d);
    chk("r39_reads", 64'(rd_addrs.size()), 64'(3));
    if (rd_addrs.size() == 3) begin
      chk("r39_addr0", 64'(rd_addrs[0]), 64'(MEMSZ - 1));
      chk("r39_addr1", 64'(rd_addrs[1]), 64'(0));
      chk("r39_addr2", 64'(rd_addrs[2]), 64'(1));
    end

    // reset mid-stream, then a clean fetch
    hdr = W'({7'd8, 7'd8});
    begin_fetch(hdr, 100, 1);
    repeat (10) @(posedge clock);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    active = 1'b0;
    @(posedge clock);
    #2;
    check_all_zero("midreset_hold");
    @(posedge clock);
    #1 reset_n = 1'b1;
    hdr = W'({7'd4, 7'd4});
    fetch(hdr, 130, 0, d);
    chk("r40_words", 64'(out_idx), 64'(4));
    chk("r40_done_cycle", 64'(d), 64'(9));

    // randomized fetches
    for (int t = 0; t < 12; t++) begin
      hdr = W'({$urandom, $urandom});
      hdr[13:7] = 7'($urandom_range(0, 10));
      hdr[6:0]  = 7'($urandom_range(0, 10));
      fetch(hdr, $urandom_range(0, MEMSZ - 1), $urandom_range(0, 2), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
